reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
Top-level sequencer for the reaction-timer game. Generates a pseudo-random arming delay and drives the stimulus LED. Starts and stops the external millisecond counter through a start/stop/done handshake, enforces a timeout and flags early presses. It sits between the debounced push-buttons and the ms counter/display path, and presents a status code plus the latched result to the display logic.

Parameters:
CLK_MS_COUNT, 100000, clk cycles per 1 ms tick (100 MHz clock)
MIN_DELAY_MS, 2000, minimum random delay before stimulus, ms
DELAY_RANGE_LOG2, 13, random delay span = 2^DELAY_RANGE_LOG2 ms added to MIN_DELAY_MS
TIMEOUT_MS, 1000, reaction timeout in ms (must be <= 1023)
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_start  in  1  debounced start button (level)
btn_stop  in  1  debounced reaction button (level)
btn_clear  in  1  debounced clear button (level)
ctr_ready  in  1  ms counter idle and able to accept start
ctr_done  in  1  ms counter 1-cycle done pulse
ctr_ms  in  10  ms counter running/final value
ctr_start  out  1  1-cycle pulse: begin counting from 0
ctr_stop  out  1  1-cycle pulse: freeze counter, produce done
stim_led  out  1  stimulus LED
status  out  3  0 HI, 1 WAIT, 2 REACT, 3 RESULT, 4 EARLY, 5 TIMEOUT
result_ms  out  10  latched reaction time
best_ms  out  10  best (minimum) valid time (see Optional Feature)

Behaviour:
- Clock `clk`; reset `rst` is synchronous and active-high. All state updates occur on posedge clk.
- Reset values: state IDLE, ctr_start=0, ctr_stop=0, stim_led=0, status=0, result_ms=0, best_ms=0, LFSR=LFSR_SEED, prescaler=0, delay counter=0, button delay regs=0.
- Buttons: rising-edge detect, one register per button; an edge is a 1-cycle event.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including in IDLE.
- ms prescaler: counts 0..CLK_MS_COUNT-1 and emits a tick at the wrap. Cleared on entry to DELAY.
- Priority: clear edge beats every other event in every state except IDLE. It goes to IDLE and forces stim_led=0. If the state is REACT, it also pulses ctr_stop; the resulting ctr_done is ignored.
- IDLE (status 0): on start edge, load delay_cnt = MIN_DELAY_MS + LFSR[DELAY_RANGE_LOG2-1:0]; go to DELAY. Stop edges are ignored.
- DELAY (status 1): delay_cnt decrements on each tick; when it reaches 0, go to ARM. A stop edge goes to EARLY with result_ms=0.
- ARM (status 1): a stop edge goes to EARLY. Otherwise, wait for ctr_ready=1; then pulse ctr_start, set stim_led=1 in the same cycle, and go to REACT. ctr_start is never asserted while ctr_ready=0.
- REACT (status 2, stim_led=1):
  - ctr_ms >= TIMEOUT_MS: pulse ctr_stop, set timeout flag, go to WAIT_DONE.
  - Else on a stop edge: pulse ctr_stop, clear timeout flag, go to WAIT_DONE.
  - If both occur in the same cycle, timeout wins.
- WAIT_DONE (status 2, stim_led=0): wait for ctr_done.
  - Timeout flag set: result_ms=TIMEOUT_MS, go to TIMEOUT.
  - Otherwise: result_ms=ctr_ms, go to RESULT.
  - Further stop edges are ignored.
- RESULT (3), EARLY (4), TIMEOUT (5): hold result_ms; start and stop edges are ignored; a clear edge goes to IDLE.
- ctr_start and ctr_stop are never asserted in the same cycle, and are never asserted for more than 1 cycle.
- result_ms persists through IDLE until overwritten. It is zeroed only by rst or by an EARLY entry.
- Latencies: stop edge to ctr_stop = 1 cycle after the edge registers; ctr_done to status update = 1 cycle.

Optional Feature:
Macro BEST_TIME_EN.
- Defined: on each RESULT entry, if best_valid=0 or ctr_ms < best_ms, then best_ms <= ctr_ms and best_valid <= 1. EARLY and TIMEOUT never update best_ms. Only rst clears best_ms; clear does not.
- Undefined: best_ms tied to 10'd0 and no comparator or register is built.

Test Plan:
(Bench uses CLK_MS_COUNT=10, MIN_DELAY_MS=4, DELAY_RANGE_LOG2=2, TIMEOUT_MS=20, with a behavioural counter model that increments ctr_ms every 10 cycles.)
- Reset then idle: rst 2 cycles -> status=0, stim_led=0, ctr_start=0, result_ms=0, best_ms=0.
- Normal run: start edge, wait for stim_led=1, press stop after 7 ms -> exactly one ctr_start, one ctr_stop, status=3, result_ms=7, best_ms=7.
- Early press: start edge, press stop 2 ms later in DELAY -> status=4, result_ms=0, no ctr_start ever issued, stim_led stays 0.
- Timeout: start, never press stop -> ctr_stop when ctr_ms=20, status=5, result_ms=20, best_ms unchanged. A simultaneous stop edge at ctr_ms=20 also yields status=5.
- Handshake and clear: hold ctr_ready=0 in ARM for 50 cycles -> no ctr_start. Release -> ctr_start in the next cycle. Clear in REACT -> ctr_stop pulse, status=0, stim_led=0.
- Best time (BEST_TIME_EN): runs of 9, 5, 12 ms with clear between -> best_ms 9, 5, 5. Rebuilt without the macro -> best_ms=0 throughout.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - reaction-timer game sequencer; optional best-time tracking under macro BEST_TIME_EN
module reaction_timer_ctrl #(
    parameter int unsigned CLK_MS_COUNT     = 100000,
    parameter int unsigned MIN_DELAY_MS     = 2000,
    parameter int unsigned DELAY_RANGE_LOG2 = 13,
    parameter int unsigned TIMEOUT_MS       = 1000,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       ctr_ready,
    input  logic       ctr_done,
    input  logic [9:0] ctr_ms,
    output logic       ctr_start,
    output logic       ctr_stop,
    output logic       stim_led,
    output logic [2:0] status,
    output logic [9:0] result_ms,
    output logic [9:0] best_ms
);

    localparam int unsigned PS_W  = (CLK_MS_COUNT > 1) ? $clog2(CLK_MS_COUNT) : 1;
    localparam int unsigned DLY_W = $clog2(MIN_DELAY_MS + (2 ** DELAY_RANGE_LOG2)) + 1;

    localparam logic [2:0] ST_HI      = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_REACT   = 3'd2;
    localparam logic [2:0] ST_RESULT  = 3'd3;
    localparam logic [2:0] ST_EARLY   = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_ARM,
        S_REACT,
        S_WAIT_DONE,
        S_RESULT,
        S_EARLY,
        S_TIMEOUT
    } state_t;

    state_t           r_state;
    logic             r_start_d;
    logic             r_stop_d;
    logic             r_clear_d;
    logic [15:0]      r_lfsr;
    logic [PS_W-1:0]  r_ps;
    logic [DLY_W-1:0] r_delay_cnt;
    logic             r_timeout;
    logic             r_ctr_start;
    logic             r_ctr_stop;
    logic             r_stim_led;
    logic [2:0]       r_status;
    logic [9:0]       r_result_ms;

    logic             w_start_edge;
    logic             w_stop_edge;
    logic             w_clear_edge;
    logic             w_tick;
    logic             w_enter_delay;
    logic             w_lfsr_fb;

    assign w_start_edge  = btn_start & ~r_start_d;
    assign w_stop_edge   = btn_stop  & ~r_stop_d;
    assign w_clear_edge  = btn_clear & ~r_clear_d;
    assign w_tick        = (r_ps == PS_W'(CLK_MS_COUNT - 1));
    assign w_enter_delay = (r_state == S_IDLE) && w_start_edge;
    assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    assign ctr_start = r_ctr_start;
    assign ctr_stop  = r_ctr_stop;
    assign stim_led  = r_stim_led;
    assign status    = r_status;
    assign result_ms = r_result_ms;

    // Button history for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d <= 1'b0;
            r_stop_d  <= 1'b0;
            r_clear_d <= 1'b0;
        end else begin
            r_start_d <= btn_start;
            r_stop_d  <= btn_stop;
            r_clear_d <= btn_clear;
        end
    end

    // Free-running LFSR; the player's start press samples it at an unpredictable phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Millisecond prescaler, restarted so the first delay tick is a full ms away
    always_ff @(posedge clk) begin
        if (rst || w_enter_delay || w_tick) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + PS_W'(1);
        end
    end

    // Main sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_delay_cnt <= '0;
            r_timeout   <= 1'b0;
            r_ctr_start <= 1'b0;
            r_ctr_stop  <= 1'b0;
            r_stim_led  <= 1'b0;
            r_status    <= ST_HI;
            r_result_ms <= '0;
        end else begin
            r_ctr_start <= 1'b0;
            r_ctr_stop  <= 1'b0;
            if ((r_state != S_IDLE) && w_clear_edge) begin
                // Abort: a running counter is frozen and its done pulse lands in IDLE unused
                if (r_state == S_REACT) begin
                    r_ctr_stop <= 1'b1;
                end
                r_stim_led <= 1'b0;
                r_status   <= ST_HI;
                r_state    <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_edge) begin
                            r_delay_cnt <= DLY_W'(MIN_DELAY_MS)
                                         + DLY_W'(r_lfsr[DELAY_RANGE_LOG2-1:0]);
                            r_status    <= ST_WAIT;
                            r_state     <= S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        if (w_stop_edge) begin
                            r_result_ms <= '0;
                            r_status    <= ST_EARLY;
                            r_state     <= S_EARLY;
                        end else if (r_delay_cnt == '0) begin
                            r_state <= S_ARM;
                        end else if (w_tick) begin
                            r_delay_cnt <= r_delay_cnt - DLY_W'(1);
                        end
                    end
                    S_ARM: begin
                        if (w_stop_edge) begin
                            r_result_ms <= '0;
                            r_status    <= ST_EARLY;
                            r_state     <= S_EARLY;
                        end else if (ctr_ready) begin
                            r_ctr_start <= 1'b1;
                            r_stim_led  <= 1'b1;
                            r_status    <= ST_REACT;
                            r_state     <= S_REACT;
                        end
                    end
                    S_REACT: begin
                        // Timeout is checked first so a press on the limit still counts as a miss
                        if (ctr_ms >= 10'(TIMEOUT_MS)) begin
                            r_ctr_stop <= 1'b1;
                            r_timeout  <= 1'b1;
                            r_stim_led <= 1'b0;
                            r_state    <= S_WAIT_DONE;
                        end else if (w_stop_edge) begin
                            r_ctr_stop <= 1'b1;
                            r_timeout  <= 1'b0;
                            r_stim_led <= 1'b0;
                            r_state    <= S_WAIT_DONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (ctr_done) begin
                            if (r_timeout) begin
                                r_result_ms <= 10'(TIMEOUT_MS);
                                r_status    <= ST_TIMEOUT;
                                r_state     <= S_TIMEOUT;
                            end else begin
                                r_result_ms <= ctr_ms;
                                r_status    <= ST_RESULT;
                                r_state     <= S_RESULT;
                            end
                        end
                    end
                    default: begin
                        // RESULT, EARLY and TIMEOUT hold until a clear edge
                    end
                endcase
            end
        end
    end

`ifdef BEST_TIME_EN
    logic       r_best_valid;
    logic [9:0] r_best_ms;
    logic       w_result_entry;

    assign w_result_entry = (r_state == S_WAIT_DONE) && ctr_done && !r_timeout && !w_clear_edge;
    assign best_ms        = r_best_ms;

    // Best valid reaction time; survives clear, only reset forgets it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_valid <= 1'b0;
            r_best_ms    <= '0;
        end else if (w_result_entry && (!r_best_valid || (ctr_ms < r_best_ms))) begin
            r_best_valid <= 1'b1;
            r_best_ms    <= ctr_ms;
        end
    end
`else
    assign best_ms = 10'd0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - directed self-checking bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;

`ifdef BEST_TIME_EN
    localparam bit BEST_ON = 1'b1;
`else
    localparam bit BEST_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_clear;
    logic       ctr_ready;
    logic       ctr_done;
    logic [9:0] ctr_ms;
    logic       ctr_start;
    logic       ctr_stop;
    logic       stim_led;
    logic [2:0] status;
    logic [9:0] result_ms;
    logic [9:0] best_ms;

    logic       ready_gate;
    logic       m_run;
    logic [3:0] m_div;
    logic [9:0] m_stop_ms;
    logic       m_prev_start;
    logic       m_prev_stop;
    int         n_start;
    int         n_stop;
    int         n_viol;

    int n_checks = 0;
    int n_fail   = 0;
    int s0;
    int p0;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(
        .CLK_MS_COUNT    (10),
        .MIN_DELAY_MS    (4),
        .DELAY_RANGE_LOG2(2),
        .TIMEOUT_MS      (20),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .btn_clear(btn_clear),
        .ctr_ready(ctr_ready),
        .ctr_done (ctr_done),
        .ctr_ms   (ctr_ms),
        .ctr_start(ctr_start),
        .ctr_stop (ctr_stop),
        .stim_led (stim_led),
        .status   (status),
        .result_ms(result_ms),
        .best_ms  (best_ms)
    );

    // Behavioural ms counter: +1 every 10 cycles, done one cycle after stop
    assign ctr_ready = !m_run && ready_gate;

    always @(posedge clk) begin
        ctr_done <= 1'b0;
        if (rst) begin
            m_run        <= 1'b0;
            m_div        <= 4'd0;
            ctr_ms       <= 10'd0;
            m_stop_ms    <= 10'd0;
            m_prev_start <= 1'b0;
            m_prev_stop  <= 1'b0;
            n_start      <= 0;
            n_stop       <= 0;
            n_viol       <= 0;
        end else begin
            m_prev_start <= ctr_start;
            m_prev_stop  <= ctr_stop;
            if ((ctr_start && ctr_stop) || (ctr_start && !ctr_ready) ||
                (ctr_start && m_prev_start) || (ctr_stop && m_prev_stop))
                n_viol <= n_viol + 1;
            if (ctr_start) begin
                n_start <= n_start + 1;
                m_run   <= 1'b1;
                m_div   <= 4'd0;
                ctr_ms  <= 10'd0;
            end else if (ctr_stop) begin
                n_stop    <= n_stop + 1;
                m_run     <= 1'b0;
                m_stop_ms <= ctr_ms;
                ctr_done  <= 1'b1;
            end else if (m_run) begin
                if (m_div == 4'd9) begin
                    m_div  <= 4'd0;
                    ctr_ms <= ctr_ms + 10'd1;
                end else begin
                    m_div <= m_div + 4'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc(2);
        btn_start = 1'b0;
        cyc(1);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        cyc(2);
        btn_clear = 1'b0;
        cyc(2);
    endtask

    task automatic wait_stim(input string tag);
        int k = 0;
        while (stim_led !== 1'b1 && k < 400) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(stim_led), 32'd1);
    endtask

    task automatic wait_ms(input string tag, input int v);
        int k = 0;
        while (ctr_ms !== 10'(v) && k < 600) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(ctr_ms), 32'(v));
    endtask

    task automatic wait_status(input string tag, input int v);
        int k = 0;
        while (status !== 3'(v) && k < 600) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(status), 32'(v));
    endtask

    task automatic run_ms(input string tag, input int v);
        press_start();
        wait_stim({tag, "_stim"});
        wait_ms({tag, "_ms"}, v);
        btn_stop = 1'b1;
        wait_status({tag, "_status"}, 3);
        btn_stop = 1'b0;
        cyc(1);
        chk({tag, "_result"}, 32'(result_ms), 32'(v));
    endtask

    initial begin
        rst        = 1'b1;
        btn_start  = 1'b0;
        btn_stop   = 1'b0;
        btn_clear  = 1'b0;
        ready_gate = 1'b1;
        cyc(2);
        rst = 1'b0;

        // Reset state
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_stim", 32'(stim_led), 32'd0);
        chk("rst_ctr_start", 32'(ctr_start), 32'd0);
        chk("rst_result", 32'(result_ms), 32'd0);
        chk("rst_best", 32'(best_ms), 32'd0);

        // Stop presses in IDLE are ignored
        btn_stop = 1'b1;
        cyc(2);
        btn_stop = 1'b0;
        cyc(1);
        chk("idle_stop_ignored", 32'(status), 32'd0);

        // Normal 7 ms run
        s0 = n_start;
        p0 = n_stop;
        run_ms("run7", 7);
        chk("run7_starts", 32'(n_start - s0), 32'd1);
        chk("run7_stops", 32'(n_stop - p0), 32'd1);
        chk("run7_best", 32'(best_ms), BEST_ON ? 32'd7 : 32'd0);
        chk("run7_stim_off", 32'(stim_led), 32'd0);
        // Start and stop in RESULT are ignored
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        cyc(2);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        cyc(1);
        chk("result_hold", 32'(status), 32'd3);
        press_clear();
        chk("clear_result", 32'(status), 32'd0);
        chk("result_persists", 32'(result_ms), 32'd7);

        // Early press 2 ms into DELAY
        s0 = n_start;
        press_start();
        cyc(17);
        chk("early_in_delay", 32'(status), 32'd1);
        btn_stop = 1'b1;
        cyc(1);
        chk("early_status", 32'(status), 32'd4);
        chk("early_result", 32'(result_ms), 32'd0);
        btn_stop = 1'b0;
        cyc(100);
        chk("early_stim", 32'(stim_led), 32'd0);
        chk("early_no_start", 32'(n_start - s0), 32'd0);
        chk("early_hold", 32'(status), 32'd4);
        press_clear();

        // Timeout with no press
        p0 = n_stop;
        press_start();
        wait_stim("to_stim");
        wait_status("to_status", 5);
        chk("to_result", 32'(result_ms), 32'd20);
        chk("to_stop_ms", 32'(m_stop_ms), 32'd20);
        chk("to_stops", 32'(n_stop - p0), 32'd1);
        chk("to_best", 32'(best_ms), BEST_ON ? 32'd7 : 32'd0);
        press_clear();

        // Stop edge in the same cycle the limit is reached: timeout wins
        press_start();
        wait_stim("tos_stim");
        wait_ms("tos_ms", 20);
        btn_stop = 1'b1;
        wait_status("tos_status", 5);
        btn_stop = 1'b0;
        chk("tos_result", 32'(result_ms), 32'd20);
        chk("tos_best", 32'(best_ms), BEST_ON ? 32'd7 : 32'd0);
        press_clear();

        // Counter busy in ARM: no start until ready, then start the very next cycle
        ready_gate = 1'b0;
        s0 = n_start;
        press_start();
        cyc(100);
        chk("hs_arm_status", 32'(status), 32'd1);
        chk("hs_no_start_a", 32'(n_start - s0), 32'd0);
        cyc(50);
        chk("hs_no_start_b", 32'(n_start - s0), 32'd0);
        chk("hs_stim_off", 32'(stim_led), 32'd0);
        ready_gate = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_start_pulse", 32'(ctr_start), 32'd1);
        chk("hs_stim_on", 32'(stim_led), 32'd1);
        chk("hs_react", 32'(status), 32'd2);
        cyc(30);
        // Clear in REACT aborts the counter
        p0 = n_stop;
        btn_clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_stop_pulse", 32'(ctr_stop), 32'd1);
        chk("clr_status", 32'(status), 32'd0);
        chk("clr_stim", 32'(stim_led), 32'd0);
        cyc(1);
        btn_clear = 1'b0;
        cyc(5);
        chk("clr_stop_once", 32'(n_stop - p0), 32'd1);
        chk("clr_done_ignored", 32'(status), 32'd0);
        chk("clr_result_kept", 32'(result_ms), 32'd20);

        // Best-time tracking from a fresh reset
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("rst2_best", 32'(best_ms), 32'd0);
        run_ms("best9", 9);
        chk("best_after9", 32'(best_ms), BEST_ON ? 32'd9 : 32'd0);
        press_clear();
        chk("best_kept_clear", 32'(best_ms), BEST_ON ? 32'd9 : 32'd0);
        run_ms("best5", 5);
        chk("best_after5", 32'(best_ms), BEST_ON ? 32'd5 : 32'd0);
        press_clear();
        run_ms("best12", 12);
        chk("best_after12", 32'(best_ms), BEST_ON ? 32'd5 : 32'd0);
        press_clear();

        chk("handshake_rules", 32'(n_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
